// File: rtl/sched_pkg.sv
// sched_pkg: shared definitions for the round-robin time-slice scheduler.
//   NUM_CH          number of requesting channels
//   SEL_CH0..SEL_CH3 mux select code for each channel (the downstream
//                   mux decodes sel with the index bits swapped)
//   state_t         FSM encoding (ST_IDLE, ST_GRANT)
//   ch_to_sel       channel index -> mux select code
package sched_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b10;
    localparam logic [1:0] SEL_CH2 = 2'b01;
    localparam logic [1:0] SEL_CH3 = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
        logic [1:0] s;
        case (ch)
            2'd0:    s = SEL_CH0;
            2'd1:    s = SEL_CH1;
            2'd2:    s = SEL_CH2;
            default: s = SEL_CH3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search.
//   req   [3:0] in   sampled request vector
//   last  [1:0] in   last-served channel
//   found       out  some request bit is set
//   idx   [1:0] out  winner: first set bit in order last+1, last+2, last+3, last
module rr_pick
    import sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        last,
    output logic              found,
    output logic [1:0]        idx
);

    always_comb begin : search
        logic [1:0] cand;
        found = 1'b0;
        idx   = last;
        cand  = last;
        // k = NUM_CH wraps back to last itself, so the previous owner is
        // only picked when nobody else is asking.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_slice_scheduler.sv
// rr_slice_scheduler: round-robin time-slice scheduler for four channels.
// Each owner keeps the downstream 4:1 mux for at most QUANTUM cycles or until
// it drops its request; ownership then rotates with no idle bubble.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req  [3:0] in   level-sensitive per-channel requests
//   grant[3:0] out  one-hot owner, 0 when idle
//   sel  [1:0] out  mux select (ch0=00 ch1=10 ch2=01 ch3=11), held when idle
//   valid      out  a channel holds the grant
//   slice_end  out  final cycle of the current quantum
//   slice_cnt  out  cycles elapsed in the current grant
// All outputs come straight from registers or from a compare on registers.
module rr_slice_scheduler
    import sched_pkg::*;
#(
    parameter int QUANTUM = 4,
    parameter int CNT_W   = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic [1:0]        sel,
    output logic              valid,
    output logic              slice_end,
    output logic [CNT_W-1:0]  slice_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

    state_t            state_q;
    logic [1:0]        owner_q;
    logic [1:0]        last_q;
    logic [NUM_CH-1:0] grant_q;
    logic [1:0]        sel_q;
    logic [CNT_W-1:0]  cnt_q;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] pick_last;

    // While granted, the search starts after the current owner so that a
    // release re-arbitrates as if last had already been updated.
    assign pick_last = (state_q == ST_GRANT) ? owner_q : last_q;

    rr_pick u_pick (
        .req   (req),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= '0;
            sel_q   <= SEL_CH0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q <= ST_GRANT;
                        owner_q <= pick_idx;
                        grant_q <= NUM_CH'(1) << pick_idx;
                        sel_q   <= ch_to_sel(pick_idx);
                        cnt_q   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (req[owner_q] && (cnt_q != CNT_MAX)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        // Early release or quantum expiry.
                        last_q <= owner_q;
                        cnt_q  <= '0;
                        if (pick_found) begin
                            owner_q <= pick_idx;
                            grant_q <= NUM_CH'(1) << pick_idx;
                            sel_q   <= ch_to_sel(pick_idx);
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign valid     = (state_q == ST_GRANT);
    assign slice_end = (state_q == ST_GRANT) && (cnt_q == CNT_MAX);
    assign slice_cnt = cnt_q;

endmodule

// File: tb/tb_rr_slice_scheduler.sv
module tb_rr_slice_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] g4, g1;
    logic [1:0] s4, s1;
    logic       v4, v1, e4, e1;
    logic [1:0] c4;
    logic [0:0] c1;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    rr_slice_scheduler #(.QUANTUM(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g4), .sel(s4), .valid(v4), .slice_end(e4), .slice_cnt(c4)
    );

    rr_slice_scheduler #(.QUANTUM(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g1), .sel(s1), .valid(v1), .slice_end(e1), .slice_cnt(c1)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       slice_end;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp4_q[$];
    exp_t exp1_q[$];

    // Reference model, one slot per instance: [0] QUANTUM=4, [1] QUANTUM=1.
    int         qv[2]      = '{4, 1};
    bit         m_busy[2];
    int         m_own[2];
    int         m_cnt[2];
    int         m_last[2];
    logic [1:0] m_sel[2];
    logic [1:0] sel_tbl[4] = '{2'b00, 2'b10, 2'b01, 2'b11};

    task automatic model_step(input int m, input logic [3:0] r, input logic rs);
        exp_t e;
        if (rs) begin
            m_busy[m] = 0; m_own[m] = 0; m_cnt[m] = 0; m_last[m] = 3; m_sel[m] = 2'b00;
        end else if (m_busy[m] && r[m_own[m]] && m_cnt[m] < qv[m] - 1) begin
            m_cnt[m]++;
        end else begin
            int base;
            bit hit;
            if (m_busy[m]) m_last[m] = m_own[m];
            base = m_last[m];
            hit  = 0;
            for (int k = 1; k <= 4; k++) begin
                int ch;
                ch = (base + k) % 4;
                if (!hit && r[ch]) begin
                    hit = 1; m_own[m] = ch;
                end
            end
            m_busy[m] = hit;
            m_cnt[m]  = 0;
            if (hit) m_sel[m] = sel_tbl[m_own[m]];
        end
        e.grant     = m_busy[m] ? (4'b0001 << m_own[m]) : 4'b0000;
        e.sel       = m_sel[m];
        e.valid     = m_busy[m];
        e.slice_end = m_busy[m] && (m_cnt[m] == qv[m] - 1);
        e.cnt       = 8'(m_cnt[m]);
        if (m == 0) exp4_q.push_back(e); else exp1_q.push_back(e);
    endtask

    // One transaction: drive req/rst, predict, clock, compare both instances.
    task automatic cyc(input logic [3:0] r, input logic rs);
        exp_t e, a;
        req = r;
        rst = rs;
        model_step(0, r, rs);
        model_step(1, r, rs);
        @(posedge clk);
        #1;
        cycle++;
        e = exp4_q.pop_front();
        a = '{grant: g4, sel: s4, valid: v4, slice_end: e4, cnt: 8'(c4)};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL q4_outputs cyc=%0d got g=%b s=%b v=%b e=%b c=%0d want g=%b s=%b v=%b e=%b c=%0d",
                     cycle, a.grant, a.sel, a.valid, a.slice_end, a.cnt,
                     e.grant, e.sel, e.valid, e.slice_end, e.cnt);
        end
        e = exp1_q.pop_front();
        a = '{grant: g1, sel: s1, valid: v1, slice_end: e1, cnt: 8'(c1)};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL q1_outputs cyc=%0d got g=%b s=%b v=%b e=%b c=%0d want g=%b s=%b v=%b e=%b c=%0d",
                     cycle, a.grant, a.sel, a.valid, a.slice_end, a.cnt,
                     e.grant, e.sel, e.valid, e.slice_end, e.cnt);
        end
        checks++;
        if (!$onehot0(g4) || v4 !== (|g4) || !$onehot0(g1) || v1 !== (|g1)) begin
            errors++;
            $display("FAIL invariant cyc=%0d got g4=%b v4=%b g1=%b v1=%b want onehot0 grant and valid==|grant",
                     cycle, g4, v4, g1, v1);
        end
        $display("cyc=%0d rst=%b req=%b | q4 g=%b s=%b v=%b e=%b c=%0d | q1 g=%b s=%b v=%b e=%b",
                 cycle, rs, r, g4, s4, v4, e4, c4, g1, s1, v1, e1);
    endtask

    task automatic do_reset();
        cyc(4'b0000, 1'b1);
    endtask

    task automatic test_reset();
        req = 4'b1111;
        cyc(4'b1111, 1'b1);
        cyc(4'b1111, 1'b1);
        checks++;
        if ({g4, s4, v4, e4, c4} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state got g=%b s=%b v=%b e=%b c=%0d want all zero", g4, s4, v4, e4, c4);
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(4'b0001, 1'b0);
            checks++;
            if (g4 !== 4'b0001 || s4 !== 2'b00 || v4 !== 1'b1 || c4 !== 2'(i % 4) || e4 !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL single_ch i=%0d got g=%b s=%b v=%b c=%0d e=%b want g=0001 s=00 v=1 c=%0d e=%b",
                         i, g4, s4, v4, c4, e4, i % 4, (i % 4 == 3));
            end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            int own;
            cyc(4'b1111, 1'b0);
            own = (i / 4) % 4;
            checks++;
            if (g4 !== (4'b0001 << own) || s4 !== sel_tbl[own]) begin
                errors++;
                $display("FAIL rotation i=%0d got g=%b s=%b want g=%b s=%b",
                         i, g4, s4, 4'b0001 << own, sel_tbl[own]);
            end
        end
    endtask

    task automatic test_idle_drop();
        do_reset();
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        cyc(4'b0000, 1'b0);
        checks++;
        if (g4 !== 4'b0000 || v4 !== 1'b0 || s4 !== 2'b01) begin
            errors++;
            $display("FAIL idle_drop got g=%b v=%b s=%b want g=0000 v=0 s=01", g4, v4, s4);
        end
        cyc(4'b1111, 1'b0);
        checks++;
        if (g4 !== 4'b1000 || s4 !== 2'b11) begin
            errors++;
            $display("FAIL idle_resume got g=%b s=%b want g=1000 s=11", g4, s4);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        cyc(4'b0101, 1'b0);
        cyc(4'b0101, 1'b0);
        cyc(4'b0100, 1'b0);
        checks++;
        if (g4 !== 4'b0100 || s4 !== 2'b01 || c4 !== 2'd0 || v4 !== 1'b1) begin
            errors++;
            $display("FAIL early_release got g=%b s=%b c=%0d v=%b want g=0100 s=01 c=0 v=1", g4, s4, c4, v4);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b1);
        checks++;
        if (g4 !== 4'b0000 || v4 !== 1'b0 || s4 !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid got g=%b v=%b s=%b want g=0000 v=0 s=00", g4, v4, s4);
        end
        cyc(4'b1111, 1'b0);
        checks++;
        if (g4 !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_next got g=%b want g=0001", g4);
        end
    endtask

    task automatic test_quantum_one();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [3:0] want;
            cyc(4'b1010, 1'b0);
            want = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++;
            if (g1 !== want || e1 !== 1'b1 || c1 !== 1'b0) begin
                errors++;
                $display("FAIL quantum_one i=%0d got g=%b e=%b c=%0d want g=%b e=1 c=0", i, g1, e1, c1, want);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            logic [3:0] r;
            logic       rs;
            r  = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 49) == 0);
            cyc(r, rs);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_rotation();
        test_idle_drop();
        test_early_release();
        test_reset_mid_grant();
        test_quantum_one();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_slice_scheduler.md
Name: rr_slice_scheduler

Overview:
- Round-robin time-slice scheduler for four requesting channels.
- Drives the select input of the downstream 4:1 channel multiplexer, plus a one-hot grant and a valid flag.
- Each granted channel holds the mux for up to QUANTUM cycles, or until it drops its request, then ownership rotates.
- Sits directly upstream of the multiplexer; the mux select comes only from this block's sel output.

Parameters:
- QUANTUM, 4, maximum consecutive cycles per grant (legal range 1..256).
- CNT_W, clog2(QUANTUM) with a minimum of 1, width of the slice counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request, level-sensitive; bit i = channel i.
- grant  output  4  one-hot granted channel; 0 when idle.
- sel  output  2  select for the downstream mux, encoded per Behaviour.
- valid  output  1  high while any channel holds the grant.
- slice_end  output  1  high during the final cycle of a quantum.
- slice_cnt  output  CNT_W  cycles elapsed in the current grant, starting at 0.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- sel encoding, fixed by the mux decode: ch0=2'b00, ch1=2'b10, ch2=2'b01, ch3=2'b11. sel bit0 is the index MSB and bit1 is the index LSB.
- sel holds its last value when idle. It is 2'b00 after reset.
- Outputs are registered or decoded only from registers; no combinational path from req to any output.
- Reset values: grant=0, sel=2'b00, valid=0, slice_end=0, slice_cnt=0, state=IDLE. The last-served pointer resets to 3, so channel 0 wins first.
- Reset mid-grant: at the next edge all state returns to reset values, regardless of req.
- States: IDLE and GRANT.
- IDLE:
  - If req!=0 at an edge, that edge loads GRANT with the winner and slice_cnt=0. valid rises the cycle after req is first sampled, giving 1-cycle latency.
  - If req==0, stay in IDLE.
- Winner search: the first set req bit in cyclic order last+1, last+2, last+3, last. The current owner is therefore considered last.
- GRANT, evaluated each edge with cur = the granted channel:
  - req[cur]=1 and slice_cnt<QUANTUM-1: increment slice_cnt; hold grant.
  - Release when req[cur]=0 (early release) or slice_cnt==QUANTUM-1 (expiry). On release, last=cur and re-arbitrate over the sampled req.
  - Winner exists: grant it at the same edge with slice_cnt=0. No idle bubble between owners.
  - No winner: go to IDLE, grant=0, valid=0.
- Expiry with only cur requesting: cur is re-granted immediately and slice_cnt wraps to 0.
- slice_end = (state==GRANT) && (slice_cnt==QUANTUM-1). It asserts even if the owner releases on that same edge.
- Early release on the expiry cycle is treated as a normal release; the results are identical.
- QUANTUM=1: slice_cnt stays 0, slice_end is constantly high in GRANT, and ownership rotates every cycle.
- Changes to req bits of non-owners never disturb the current grant.
- Invariants:
  - grant is always one-hot or zero.
  - valid == |grant.
  - sel always matches grant per the encoding table whenever valid=1.

Decomposition:
- Shared package sched_pkg holds:
  - NUM_CH=4.
  - Channel-to-sel constants SEL_CH0..SEL_CH3 (00, 10, 01, 11).
  - State encoding constants ST_IDLE and ST_GRANT.
- One natural sub-module, rr_pick: purely combinational.
  - Inputs: req[3:0], last[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once in rr_slice_scheduler.

Test Plan:
1. Reset, then req=0001 held. Expect: grant=0001, sel=00, valid=1 from the edge after req is sampled. slice_cnt runs 0,1,2,3 with slice_end=1 at cnt=3, then re-grant to ch0 with cnt=0, no valid gap.
2. req=1111 constant, QUANTUM=4. Expect grant 0001→0010→0100→1000→0001, 4 cycles each, and sel 00→10→01→11→00 in step.
3. Only ch2 requesting; req drops to 0000 at slice_cnt=1. Expect next cycle grant=0000, valid=0, sel held at 01. Then req=1111 grants ch3 (grant=1000, sel=11) first.
4. req=0101, ch0 owns; ch0 drops its bit at slice_cnt=1. Expect next edge grant=0100, sel=01, slice_cnt=0, valid continuously 1.
5. req=1111, rst pulsed for 1 cycle mid-slice on ch1. Expect grant=0, valid=0, sel=00 after the reset edge. The next grant after release is ch0.
6. QUANTUM=1 build with req=1010. Expect grant alternating 0010,1000 every cycle, slice_end=1 throughout, slice_cnt=0.
